uart_rx_fifo: RTL and testbench

Receive-side buffer sitting directly downstream of the UART receiver. It drives the receiver's `clear` input to re-arm it after every byte and captures each completed byte into a small synchronous FIFO. It presents the head byte to the CPU as one memory-mapped 16-bit word with the same "bit 15 = 1 means nothing available" convention the receiver uses. This decouples CPU polling rate from line rate so back-to-back bytes are not lost.

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_rx_fifo_byte_fifo.sv | 62 ++++++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared encodings for the UART receive buffer: FSM states, word bit positions
// and the "nothing available" word.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ARM        = 2'd0,
        WAIT_ARMED = 2'd1,
        WAIT_BYTE  = 2'd2
    } rx_state_e;

    localparam int unsigned RX_READY_BIT = 15;
    localparam int unsigned OVR_BIT      = 14;
    localparam logic [15:0] EMPTY_WORD   = 16'h8000;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy; head entry read combinationally.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [7:0]                 i_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [7:0]                 o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || i_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: re-arms it after every byte, queues
// completed bytes and presents the head byte plus flags as one CPU word.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ARM_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                rx_out,
    output logic                       rx_clear,
    input  logic                       cpu_pop,
    output logic [15:0]                cpu_out,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned TW = $clog2(ARM_TIMEOUT + 1);

    rx_state_e     r_state;
    rx_state_e     w_state_next;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_next;
    logic          r_ovr;
    logic          r_rx_clear;
    logic          w_push;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [15:0]   w_cpu_word;
    logic          w_unused;

    assign w_unused = ^rx_out[14:8];

    // A push that the FIFO cannot take marks an overrun.
    assign w_drop = w_push && w_full && !cpu_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARM;
            r_tmo      <= '0;
            r_ovr      <= 1'b0;
            r_rx_clear <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_tmo      <= w_tmo_next;
            r_rx_clear <= (w_state_next == ARM);
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (cpu_pop) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo;
        w_push       = 1'b0;
        case (r_state)
            ARM: begin
                w_state_next = WAIT_ARMED;
            end
            WAIT_ARMED: begin
                if (rx_out[RX_READY_BIT]) begin
                    w_state_next = WAIT_BYTE;
                    w_tmo_next   = '0;
                end else if (r_tmo == TW'(ARM_TIMEOUT - 1)) begin
                    // Receiver never showed ready: pulse clear again.
                    w_state_next = ARM;
                    w_tmo_next   = '0;
                end else begin
                    w_tmo_next = r_tmo + TW'(1);
                end
            end
            WAIT_BYTE: begin
                if (!rx_out[RX_READY_BIT]) begin
                    w_push       = 1'b1;
                    w_state_next = ARM;
                end
            end
            default: begin
                w_state_next = ARM;
                w_tmo_next   = '0;
            end
        endcase
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (rx_out[7:0]),
        .i_pop   (cpu_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count),
        .o_head  (w_head)
    );

    always_comb begin
        w_cpu_word          = w_empty ? EMPTY_WORD : {8'h00, w_head};
        w_cpu_word[OVR_BIT] = r_ovr;
    end

    assign cpu_out  = w_cpu_word;
    assign rx_clear = r_rx_clear;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: the bench plays the UART receiver by driving
// rx_out cycle by cycle and checks the CPU word, occupancy and clear pulses.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rx_out;
    logic        rx_clear;
    logic        cpu_pop;
    logic [15:0] cpu_out;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(
        .DEPTH       (16),
        .ARM_TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_out   (rx_out),
        .rx_clear (rx_clear),
        .cpu_pop  (cpu_pop),
        .cpu_out  (cpu_out),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte completes while the FSM waits in WAIT_BYTE; receiver re-arms after the clear cycle.
    task automatic deliver(input logic [7:0] b, input logic pop);
        rx_out  = {8'h00, b};
        cpu_pop = pop;
        tick();
        cpu_pop = 1'b0;
        rx_out  = 16'h8000;
        tick();
        tick();
    endtask

    task automatic pop_one();
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rx_out  = 16'h8000;
        cpu_pop = 1'b0;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_clear", 32'(rx_clear), 32'd1);
            chk("rst_cpu",   32'(cpu_out),  32'h8000);
            chk("rst_count", 32'(count),    32'd0);
        end
        reset = 1'b0;
        chk("post_rst_clear_hi", 32'(rx_clear), 32'd1);
        tick();
        chk("post_rst_clear_lo", 32'(rx_clear), 32'd0);
        tick();

        // Single byte 0x41
        rx_out = 16'h0041;
        tick();
        chk("single_cpu",   32'(cpu_out),  32'h0041);
        chk("single_count", 32'(count),    32'd1);
        chk("single_clear", 32'(rx_clear), 32'd1);
        rx_out = 16'h8000;
        tick();
        chk("single_clear_lo", 32'(rx_clear), 32'd0);
        tick();
        pop_one();
        chk("single_pop_cpu",   32'(cpu_out), 32'h8000);
        chk("single_pop_count", 32'(count),   32'd0);

        // Ordering across pointer wrap: 0x00..0x13
        for (int i = 0; i < 10; i++) deliver(8'(i), 1'b0);
        chk("wrap_count10", 32'(count), 32'd10);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wrap_head_%0d", i), 32'(cpu_out), 32'(i));
            pop_one();
        end
        for (int i = 10; i < 20; i++) deliver(8'(i), 1'b0);
        chk("wrap_count15", 32'(count), 32'd15);
        for (int i = 5; i < 20; i++) begin
            chk($sformatf("wrap_head_%0d", i), 32'(cpu_out), 32'(i));
            pop_one();
        end
        chk("wrap_empty", 32'(cpu_out), 32'h8000);
        chk("wrap_count0", 32'(count), 32'd0);

        // Overrun: 16 bytes 0x20..0x2F, then 0x55 dropped
        for (int i = 0; i < 16; i++) deliver(8'(32 + i), 1'b0);
        chk("ovr_full_count", 32'(count), 32'd16);
        chk("ovr_full_cpu",   32'(cpu_out), 32'h0020);
        deliver(8'h55, 1'b0);
        chk("ovr_flag_cpu",   32'(cpu_out), 32'h4020);
        chk("ovr_count",      32'(count), 32'd16);
        pop_one();
        chk("ovr_pop_cpu",    32'(cpu_out), 32'h0021);
        chk("ovr_pop_count",  32'(count), 32'd15);

        // Full with simultaneous push+pop
        deliver(8'h30, 1'b0);
        chk("pp_full_count", 32'(count), 32'd16);
        rx_out  = 16'h007E;
        cpu_pop = 1'b1;
        tick();
        cpu_pop = 1'b0;
        rx_out  = 16'h8000;
        chk("pp_cpu",   32'(cpu_out), 32'h0022);
        chk("pp_count", 32'(count), 32'd16);
        tick();
        tick();
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("pp_head_%0d", i), 32'(cpu_out), 32'(34 + i));
            pop_one();
        end
        chk("pp_head_30", 32'(cpu_out), 32'h0030);
        pop_one();
        chk("pp_head_7e", 32'(cpu_out), 32'h007E);
        pop_one();
        chk("pp_empty", 32'(cpu_out), 32'h8000);

        // Stuck receiver: bit15 never rises, clear re-pulses every 5 cycles
        reset  = 1'b1;
        rx_out = 16'h0011;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("stuck_clear_%0d", i), 32'(rx_clear), ((i % 5) == 0) ? 32'd1 : 32'd0);
            tick();
        end
        chk("stuck_count", 32'(count), 32'd0);
        chk("stuck_cpu",   32'(cpu_out), 32'h8000);

        // Reset during WAIT_BYTE discards the queued byte and restarts in ARM
        reset  = 1'b1;
        rx_out = 16'h8000;
        tick();
        reset = 1'b0;
        tick();
        tick();
        deliver(8'h66, 1'b0);
        chk("midrst_pre_cpu", 32'(cpu_out), 32'h0066);
        reset  = 1'b1;
        rx_out = 16'h0077;
        tick();
        chk("midrst_cpu",   32'(cpu_out),  32'h8000);
        chk("midrst_count", 32'(count),    32'd0);
        chk("midrst_clear", 32'(rx_clear), 32'd1);
        reset = 1'b0;
        chk("midrst_arm", 32'(rx_clear), 32'd1);
        tick();
        chk("midrst_noarm", 32'(rx_clear), 32'd0);
        chk("midrst_nopush", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
